// File: rtl/inst_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetcher
// Description : Front-end fetch stage. Owns the fetch PC, issues icache
//               requests, predicts the next PC (JAL, predicted branches) and
//               hands instructions to the decoder through a one-entry
//               valid/ready output register. ROB redirects abort the current
//               fetch; an icache request already in flight is drained first.
//               Optional feature macro: IF_JALR_STALL_EN (halt fetch after a
//               JALR until the ROB redirects).
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        if_to_ic_req,
    output logic [31:0] if_to_ic_PC,
    input  logic        ic_to_if_hit,
    input  logic [31:0] ic_to_if_inst,
    output logic [31:0] if_to_pr_PC,
    input  logic        pr_to_if_prediction,
    input  logic        dec_to_if_ready,
    output logic        if_to_dec_valid,
    output logic [31:0] if_to_dec_inst,
    output logic [31:0] if_to_dec_PC,
    output logic        if_to_dec_pred_taken,
    input  logic        rob_to_if_flush,
    input  logic [31:0] rob_to_if_target_PC
);

    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
`ifdef IF_JALR_STALL_EN
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
`endif

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1
`ifdef IF_JALR_STALL_EN
        , ST_HALT = 2'd2
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    // Redirect target held while a stale icache request drains; the PC
    // register keeps the stale address so the icache sees a stable request.
    logic [31:0] redirect_q, redirect_d;
    // Clear for the first cycle after reset so req is low while in reset.
    logic        run_q, run_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        out_pt_q, out_pt_d;

    logic [31:0] w_j_imm;
    logic [31:0] w_b_imm;
    logic [31:0] w_next_pc;
    logic        w_pred_taken;
    logic        w_req;
    logic        w_xfer;
`ifdef IF_JALR_STALL_EN
    logic        w_is_jalr;
`endif

    assign w_j_imm = {{11{ic_to_if_inst[31]}}, ic_to_if_inst[31], ic_to_if_inst[19:12],
                      ic_to_if_inst[20], ic_to_if_inst[30:21], 1'b0};
    assign w_b_imm = {{19{ic_to_if_inst[31]}}, ic_to_if_inst[31], ic_to_if_inst[7],
                      ic_to_if_inst[30:25], ic_to_if_inst[11:8], 1'b0};
    assign w_xfer  = out_valid_q & dec_to_if_ready;
`ifdef IF_JALR_STALL_EN
    assign w_is_jalr = (ic_to_if_inst[6:0] == c_op_jalr);
`endif

    // Speculative next PC and predicted direction for the returning instruction
    always_comb begin
        w_next_pc    = pc_q + 32'd4;
        w_pred_taken = 1'b0;
        case (ic_to_if_inst[6:0])
            c_op_jal: begin
                w_next_pc    = pc_q + w_j_imm;
                w_pred_taken = 1'b1;
            end
            c_op_branch: begin
                w_pred_taken = pr_to_if_prediction;
                if (pr_to_if_prediction) begin
                    w_next_pc = pc_q + w_b_imm;
                end
            end
            default: begin
                // JALR and non-control instructions fall through sequentially
            end
        endcase
    end

    // Icache request: held while a request is owed, withheld on output back-pressure
    always_comb begin
        w_req = 1'b0;
        case (state_q)
            ST_FETCH: w_req = run_q & ~(out_valid_q & ~dec_to_if_ready);
            ST_DRAIN: w_req = 1'b1;
            default:  w_req = 1'b0;
        endcase
    end

    // Next-state, PC and output-register update; everything frozen while rdy_in is low
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redirect_d  = redirect_q;
        run_d       = run_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_pt_d    = out_pt_q;

        if (rdy_in) begin
            run_d = 1'b1;
            if (w_xfer) begin
                out_valid_d = 1'b0;
            end

            case (state_q)
                ST_FETCH: begin
                    if (rob_to_if_flush) begin
                        out_valid_d = 1'b0;
                        if (w_req && !ic_to_if_hit) begin
                            // Request in flight: keep presenting it until answered
                            state_d    = ST_DRAIN;
                            redirect_d = rob_to_if_target_PC;
                        end else begin
                            pc_d = rob_to_if_target_PC;
                        end
                    end else if (ic_to_if_hit) begin
                        out_valid_d = 1'b1;
                        out_inst_d  = ic_to_if_inst;
                        out_pc_d    = pc_q;
                        out_pt_d    = w_pred_taken;
`ifdef IF_JALR_STALL_EN
                        if (w_is_jalr) begin
                            state_d = ST_HALT;
                        end else begin
                            pc_d = w_next_pc;
                        end
`else
                        pc_d = w_next_pc;
`endif
                    end
                end

                ST_DRAIN: begin
                    if (rob_to_if_flush) begin
                        out_valid_d = 1'b0;
                        redirect_d  = rob_to_if_target_PC;
                    end
                    if (ic_to_if_hit) begin
                        // Stale response is dropped; resume at the newest target
                        state_d = ST_FETCH;
                        pc_d    = rob_to_if_flush ? rob_to_if_target_PC : redirect_q;
                    end
                end

`ifdef IF_JALR_STALL_EN
                ST_HALT: begin
                    if (rob_to_if_flush) begin
                        out_valid_d = 1'b0;
                        pc_d        = rob_to_if_target_PC;
                        state_d     = ST_FETCH;
                    end
                end
`endif

                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            redirect_q  <= RESET_PC;
            run_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'd0;
            out_pc_q    <= 32'd0;
            out_pt_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redirect_q  <= redirect_d;
            run_q       <= run_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_pt_q    <= out_pt_d;
        end
    end

    assign if_to_ic_req         = w_req;
    assign if_to_ic_PC          = pc_q;
    assign if_to_pr_PC          = pc_q;
    assign if_to_dec_valid      = out_valid_q;
    assign if_to_dec_inst       = out_inst_q;
    assign if_to_dec_PC         = out_pc_q;
    assign if_to_dec_pred_taken = out_pt_q;

endmodule
`default_nettype wire
